// File: rtl/rob_retire_pkg.sv
// rtl/rob_retire_pkg.sv - shared ROB sizes, entry/dispatch/retire structs and helpers
package rob_retire_pkg;

    localparam int ROB_ENTRY_NUM = 32;
    localparam int ROB_IDX_W     = $clog2(ROB_ENTRY_NUM);
    localparam int CNT_W         = ROB_IDX_W + 1;
    localparam int DP_NUM        = 2;
    localparam int RT_NUM        = 2;
    localparam int CDB_NUM       = 2;
    localparam int PR_ENTRY      = 64;
    localparam int TAG_W         = $clog2(PR_ENTRY);
    localparam int ARCH_W        = 5;

    localparam logic [TAG_W-1:0] ZERO_PREG = '0;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic              mispred;
        logic [ARCH_W-1:0] arch_rd;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  tag_old;
    } ROB_ENTRY;

    // Consumed as-is by the freelist on its rob_fl_i port.
    typedef struct packed {
        logic [RT_NUM-1:0]             rt_num;
        logic [RT_NUM-1:0][TAG_W-1:0]  phy_reg;
        logic [RT_NUM-1:0][TAG_W-1:0]  tag;
    } ROB_FL;

    typedef struct packed {
        logic [DP_NUM-1:0]              dp_num;
        logic [DP_NUM-1:0][ARCH_W-1:0]  arch_rd;
        logic [DP_NUM-1:0][TAG_W-1:0]   tag;
        logic [DP_NUM-1:0][TAG_W-1:0]   tag_old;
    } DP_ROB;

    typedef struct packed {
        logic [DP_NUM-1:0]                 avail;
        logic [DP_NUM-1:0][ROB_IDX_W-1:0]  idx;
    } ROB_DP;

    function automatic logic [1:0] pop2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/rob_retire_if.sv
// rtl/rob_retire_if.sv - dispatch, completion, retire and rollback signals of the ROB
interface rob_retire_if;
    import rob_retire_pkg::*;

    logic [DP_NUM-1:0]                 dp_num_i;
    logic [DP_NUM-1:0][ARCH_W-1:0]     dp_arch_rd_i;
    logic [DP_NUM-1:0][TAG_W-1:0]      dp_tag_i;
    logic [DP_NUM-1:0][TAG_W-1:0]      dp_tag_old_i;
    logic [DP_NUM-1:0]                 rob_dp_avail_o;
    logic [DP_NUM-1:0][ROB_IDX_W-1:0]  rob_dp_idx_o;
    logic [CDB_NUM-1:0]                cdb_valid_i;
    logic [CDB_NUM-1:0][ROB_IDX_W-1:0] cdb_rob_idx_i;
    logic [CDB_NUM-1:0]                cdb_mispred_i;
    logic [RT_NUM-1:0]                 rt_num_o;
    logic [RT_NUM-1:0][TAG_W-1:0]      rt_phy_reg_o;
    logic [RT_NUM-1:0][TAG_W-1:0]      rt_tag_o;
    logic [RT_NUM-1:0][ARCH_W-1:0]     rt_arch_rd_o;
    logic                              rollback_o;
    logic [TAG_W-1:0]                  rollback_tag_o;

    modport master (
        output dp_num_i, dp_arch_rd_i, dp_tag_i, dp_tag_old_i,
        output cdb_valid_i, cdb_rob_idx_i, cdb_mispred_i,
        input  rob_dp_avail_o, rob_dp_idx_o,
        input  rt_num_o, rt_phy_reg_o, rt_tag_o, rt_arch_rd_o,
        input  rollback_o, rollback_tag_o
    );

    modport slave (
        input  dp_num_i, dp_arch_rd_i, dp_tag_i, dp_tag_old_i,
        input  cdb_valid_i, cdb_rob_idx_i, cdb_mispred_i,
        output rob_dp_avail_o, rob_dp_idx_o,
        output rt_num_o, rt_phy_reg_o, rt_tag_o, rt_arch_rd_o,
        output rollback_o, rollback_tag_o
    );

endinterface

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - retire lane selection and mispredict gating from the two oldest entries
module rob_retire_sel
    import rob_retire_pkg::*;
(
    input  logic              head_valid,
    input  logic              head_complete,
    input  logic              head_mispred,
    input  logic              next_valid,
    input  logic              next_complete,
    output logic [RT_NUM-1:0] rt_num,
    output logic              rollback
);

    logic head_rt;

    assign head_rt = head_valid && head_complete;

    // A mispredicted head retires alone; everything younger is squashed.
    always_comb begin
        rt_num    = '0;
        rt_num[0] = head_rt;
        rt_num[1] = head_rt && !head_mispred && next_valid && next_complete;
    end

    assign rollback = head_rt && head_mispred;

endmodule

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - 2-wide reorder buffer: in-order allocate, CDB complete, up to 2 retires/cycle
// Define ROB_DEBUG_EN for head/tail/count/valid/complete debug ports and protocol assertions.
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    rob_retire_if.slave              rob_if
`ifdef ROB_DEBUG_EN
    ,
    output logic [ROB_IDX_W-1:0]     head_o,
    output logic [ROB_IDX_W-1:0]     tail_o,
    output logic [CNT_W-1:0]         count_o,
    output logic [ROB_ENTRY_NUM-1:0] valid_o,
    output logic [ROB_ENTRY_NUM-1:0] complete_o
`endif
);

    ROB_ENTRY               rob_q [ROB_ENTRY_NUM];
    logic [ROB_IDX_W-1:0]   head_q, tail_q, head_p1, tail_p1;
    logic [CNT_W-1:0]       count_q, free_cnt;
    DP_ROB                  dp;
    ROB_DP                  rob_dp;
    ROB_FL                  rob_fl;
    ROB_ENTRY               rt_entry [RT_NUM];
    logic [ROB_IDX_W-1:0]   rt_slot  [RT_NUM];
    logic [ROB_IDX_W-1:0]   dp_slot  [DP_NUM];
    logic [RT_NUM-1:0][ARCH_W-1:0] rt_arch_rd;
    logic [DP_NUM-1:0]      dp_acc;
    logic [RT_NUM-1:0]      rt_num;
    logic                   rollback;
    logic [TAG_W-1:0]       rollback_tag;

    assign head_p1  = head_q + ROB_IDX_W'(1);
    assign tail_p1  = tail_q + ROB_IDX_W'(1);
    assign free_cnt = CNT_W'(ROB_ENTRY_NUM) - count_q;

    assign dp = '{dp_num:  rob_if.dp_num_i,  arch_rd: rob_if.dp_arch_rd_i,
                  tag:     rob_if.dp_tag_i,  tag_old: rob_if.dp_tag_old_i};

    // Capacity comes from the registered count only, so a retire this cycle frees nothing yet.
    always_comb begin
        rob_dp.avail = 2'b00;
        if (free_cnt >= CNT_W'(2))
            rob_dp.avail = 2'b11;
        else if (free_cnt == CNT_W'(1))
            rob_dp.avail = 2'b01;
        rob_dp.idx = {tail_p1, tail_q};
    end

    assign dp_acc = dp.dp_num & rob_dp.avail;

    always_comb begin
        rt_slot[0]  = head_q;
        rt_slot[1]  = head_p1;
        dp_slot[0]  = tail_q;
        dp_slot[1]  = tail_p1;
        rt_entry[0] = rob_q[head_q];
        rt_entry[1] = rob_q[head_p1];
    end

    rob_retire_sel u_sel (
        .head_valid    (rt_entry[0].valid),
        .head_complete (rt_entry[0].complete),
        .head_mispred  (rt_entry[0].mispred),
        .next_valid    (rt_entry[1].valid),
        .next_complete (rt_entry[1].complete),
        .rt_num        (rt_num),
        .rollback      (rollback)
    );

    always_comb begin
        rob_fl        = '0;
        rt_arch_rd    = '0;
        rob_fl.rt_num = rt_num;
        for (int l = 0; l < RT_NUM; l++) begin
            rob_fl.phy_reg[l] = rt_num[l] ? rt_entry[l].tag_old : ZERO_PREG;
            rob_fl.tag[l]     = rt_num[l] ? rt_entry[l].tag     : ZERO_PREG;
            rt_arch_rd[l]     = rt_num[l] ? rt_entry[l].arch_rd : '0;
        end
        rollback_tag = rollback ? rt_entry[0].tag : ZERO_PREG;
    end

    assign rob_if.rob_dp_avail_o = rob_dp.avail;
    assign rob_if.rob_dp_idx_o   = rob_dp.idx;
    assign rob_if.rt_num_o       = rob_fl.rt_num;
    assign rob_if.rt_phy_reg_o   = rob_fl.phy_reg;
    assign rob_if.rt_tag_o       = rob_fl.tag;
    assign rob_if.rt_arch_rd_o   = rt_arch_rd;
    assign rob_if.rollback_o     = rollback;
    assign rob_if.rollback_tag_o = rollback_tag;

    // Update order matters: completion, then retire clear, then dispatch write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_ENTRY_NUM; i++)
                rob_q[i] <= '0;
        end else if (rollback) begin
            head_q  <= head_p1;
            tail_q  <= head_p1;
            count_q <= '0;
            for (int i = 0; i < ROB_ENTRY_NUM; i++)
                rob_q[i] <= '0;
        end else begin
            for (int c = 0; c < CDB_NUM; c++) begin
                if (rob_if.cdb_valid_i[c] && rob_q[rob_if.cdb_rob_idx_i[c]].valid) begin
                    rob_q[rob_if.cdb_rob_idx_i[c]].complete <= 1'b1;
                    rob_q[rob_if.cdb_rob_idx_i[c]].mispred  <= rob_if.cdb_mispred_i[c];
                end
            end
            for (int l = 0; l < RT_NUM; l++) begin
                if (rt_num[l])
                    rob_q[rt_slot[l]] <= '0;
            end
            for (int d = 0; d < DP_NUM; d++) begin
                if (dp_acc[d])
                    rob_q[dp_slot[d]] <= '{valid: 1'b1, complete: 1'b0, mispred: 1'b0,
                                           arch_rd: dp.arch_rd[d], tag: dp.tag[d],
                                           tag_old: dp.tag_old[d]};
            end
            head_q  <= head_q + ROB_IDX_W'(pop2(rt_num));
            tail_q  <= tail_q + ROB_IDX_W'(pop2(dp_acc));
            count_q <= count_q + CNT_W'(pop2(dp_acc)) - CNT_W'(pop2(rt_num));
        end
    end

`ifdef ROB_DEBUG_EN
    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

    always_comb begin
        valid_o    = '0;
        complete_o = '0;
        for (int i = 0; i < ROB_ENTRY_NUM; i++) begin
            valid_o[i]    = rob_q[i].valid;
            complete_o[i] = rob_q[i].complete;
        end
    end

    a_dp_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (rob_if.dp_num_i & ~rob_dp.avail) == '0);
    a_dp_num_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        rob_if.dp_num_i != 2'b10);
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_q <= CNT_W'(ROB_ENTRY_NUM));
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - directed bench for rob_retire with a queue-based program-order model
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_retire_if rob_if();

`ifdef ROB_DEBUG_EN
    logic [ROB_IDX_W-1:0]     dbg_head, dbg_tail;
    logic [CNT_W-1:0]         dbg_count;
    logic [ROB_ENTRY_NUM-1:0] dbg_valid, dbg_complete;
`endif

    rob_retire dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rob_if     (rob_if.slave)
`ifdef ROB_DEBUG_EN
        ,
        .head_o     (dbg_head),
        .tail_o     (dbg_tail),
        .count_o    (dbg_count),
        .valid_o    (dbg_valid),
        .complete_o (dbg_complete)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: the ROB is the list of in-flight instructions, oldest first.
    typedef struct {
        int         idx;
        logic [4:0] arch;
        logic [5:0] tag;
        logic [5:0] told;
        bit         comp;
        bit         misp;
    } ment_t;

    ment_t q[$];
    int    m_head = 0;

    function automatic int m_avail();
        int f;
        f = ROB_ENTRY_NUM - q.size();
        if (f >= 2) return 3;
        if (f == 1) return 1;
        return 0;
    endfunction

    function automatic int m_rt();
        if (q.size() == 0 || !q[0].comp) return 0;
        if (q[0].misp) return 1;
        if (q.size() > 1 && q[1].comp) return 3;
        return 1;
    endfunction

    function automatic bit m_roll();
        return q.size() > 0 && q[0].comp && q[0].misp;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        int    rt, av, tl;
        ment_t e;
        if (!rst_n) begin
            q.delete();
            m_head = 0;
        end else begin
            rt = m_rt();
            av = m_avail();
            tl = (m_head + q.size()) % ROB_ENTRY_NUM;
            if (m_roll()) begin
                q.delete();
                m_head = (m_head + 1) % ROB_ENTRY_NUM;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (rob_if.cdb_valid_i[c]) begin
                        foreach (q[k]) begin
                            if (q[k].idx == int'(rob_if.cdb_rob_idx_i[c])) begin
                                q[k].comp = 1'b1;
                                q[k].misp = rob_if.cdb_mispred_i[c];
                            end
                        end
                    end
                end
                for (int l = 0; l < 2; l++) begin
                    if (rt[l]) begin
                        void'(q.pop_front());
                        m_head = (m_head + 1) % ROB_ENTRY_NUM;
                    end
                end
                for (int d = 0; d < 2; d++) begin
                    if (rob_if.dp_num_i[d] && av[d]) begin
                        e.idx  = (tl + d) % ROB_ENTRY_NUM;
                        e.arch = rob_if.dp_arch_rd_i[d];
                        e.tag  = rob_if.dp_tag_i[d];
                        e.told = rob_if.dp_tag_old_i[d];
                        e.comp = 1'b0;
                        e.misp = 1'b0;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int         rt, t0;
        logic [5:0] e_phy [2];
        logic [5:0] e_tag [2];
        logic [4:0] e_arch [2];
        logic [5:0] e_rbt;
        rt = m_rt();
        t0 = (m_head + q.size()) % ROB_ENTRY_NUM;
        e_rbt = 6'd0;
        for (int l = 0; l < 2; l++) begin
            e_phy[l]  = 6'd0;
            e_tag[l]  = 6'd0;
            e_arch[l] = 5'd0;
            if (rt[l]) begin
                e_phy[l]  = q[l].told;
                e_tag[l]  = q[l].tag;
                e_arch[l] = q[l].arch;
            end
        end
        if (m_roll()) e_rbt = q[0].tag;
        chk("avail",        rob_if.rob_dp_avail_o, m_avail());
        chk("dp_idx0",      rob_if.rob_dp_idx_o[0], t0);
        chk("dp_idx1",      rob_if.rob_dp_idx_o[1], (t0 + 1) % ROB_ENTRY_NUM);
        chk("rt_num",       rob_if.rt_num_o, rt);
        chk("rollback",     rob_if.rollback_o, m_roll());
        chk("rollback_tag", rob_if.rollback_tag_o, e_rbt);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("rt_phy%0d", l),  rob_if.rt_phy_reg_o[l], e_phy[l]);
            chk($sformatf("rt_tag%0d", l),  rob_if.rt_tag_o[l],     e_tag[l]);
            chk($sformatf("rt_arch%0d", l), rob_if.rt_arch_rd_o[l], e_arch[l]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_if.dp_num_i      = '0;
        rob_if.dp_arch_rd_i  = '0;
        rob_if.dp_tag_i      = '0;
        rob_if.dp_tag_old_i  = '0;
        rob_if.cdb_valid_i   = '0;
        rob_if.cdb_rob_idx_i = '0;
        rob_if.cdb_mispred_i = '0;
    endtask

    task automatic dispatch(input logic [1:0] m, input logic [5:0] tag0, input logic [5:0] tag1,
                            input logic [5:0] told0, input logic [5:0] told1);
        rob_if.dp_num_i        = m;
        rob_if.dp_tag_i[0]     = tag0;
        rob_if.dp_tag_i[1]     = tag1;
        rob_if.dp_tag_old_i[0] = told0;
        rob_if.dp_tag_old_i[1] = told1;
        rob_if.dp_arch_rd_i[0] = told0[4:0];
        rob_if.dp_arch_rd_i[1] = told1[4:0];
    endtask

    task automatic complete(input logic [1:0] v, input int i0, input int i1, input logic [1:0] mp);
        rob_if.cdb_valid_i      = v;
        rob_if.cdb_rob_idx_i[0] = 5'(i0);
        rob_if.cdb_rob_idx_i[1] = 5'(i1);
        rob_if.cdb_mispred_i    = mp;
    endtask

    initial begin
        int n;
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_rt_num",   rob_if.rt_num_o, 0);
        chk("rst_avail",    rob_if.rob_dp_avail_o, 2'b11);
        chk("rst_idx",      rob_if.rob_dp_idx_o, {5'd1, 5'd0});
        chk("rst_rollback", rob_if.rollback_o, 0);
        rst_n = 1'b1;
        tick();

        dispatch(2'b11, 6'd32, 6'd33, 6'd1, 6'd2);
        chk("first_idx", rob_if.rob_dp_idx_o, {5'd1, 5'd0});
        tick(); idle();
        chk("two_avail", rob_if.rob_dp_avail_o, 2'b11);
        chk("two_count", q.size(), 2);
        complete(2'b01, 1, 0, 2'b00);
        tick(); idle();
        chk("young_first_no_rt", rob_if.rt_num_o, 0);
        complete(2'b01, 0, 0, 2'b00);
        tick(); idle();
        chk("pair_rt_num", rob_if.rt_num_o, 2'b11);
        chk("pair_phy",    rob_if.rt_phy_reg_o, {6'd2, 6'd1});
        chk("pair_tag",    rob_if.rt_tag_o, {6'd33, 6'd32});
        tick();
        chk("pair_drained", q.size(), 0);

        n = 0;
        repeat (15) begin
            dispatch(2'b11, 6'(n + 8), 6'(n + 9), 6'(n), 6'(n + 1));
            n += 2;
            tick();
        end
        dispatch(2'b01, 6'(n + 8), 6'd0, 6'(n), 6'd0);
        n++;
        tick(); idle();
        chk("fill31_avail", rob_if.rob_dp_avail_o, 2'b01);
        dispatch(2'b01, 6'(n + 8), 6'd0, 6'(n), 6'd0);
        tick(); idle();
        chk("full_avail", rob_if.rob_dp_avail_o, 2'b00);
        complete(2'b01, 2, 0, 2'b00);
        tick(); idle();
        chk("full_rt_one",     rob_if.rt_num_o, 2'b01);
        chk("full_same_avail", rob_if.rob_dp_avail_o, 2'b00);
        tick();
        chk("after_rt_avail",  rob_if.rob_dp_avail_o, 2'b01);

        complete(2'b11, 3, 4, 2'b01);
        tick(); idle();
        dispatch(2'b01, 6'd50, 6'd0, 6'd50, 6'd0);
        chk("mp_rt_num",   rob_if.rt_num_o, 2'b01);
        chk("mp_rollback", rob_if.rollback_o, 1);
        chk("mp_tag",      rob_if.rollback_tag_o, 6'd9);
        tick(); idle();
        chk("mp_avail",    rob_if.rob_dp_avail_o, 2'b11);
        chk("mp_idx",      rob_if.rob_dp_idx_o, {5'd5, 5'd4});
        chk("mp_count",    q.size(), 0);

        for (int j = 0; j < 13; j++) begin
            dispatch(2'b11, 6'(2 * j + 10), 6'(2 * j + 11), 6'(2 * j + 10), 6'(2 * j + 11));
            tick();
        end
        idle();
        for (int j = 0; j < 13; j++) begin
            complete(2'b11, 4 + 2 * j, 5 + 2 * j, 2'b00);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("wrap_head",  m_head, 30);
        chk("wrap_empty", q.size(), 0);
        dispatch(2'b11, 6'd40, 6'd41, 6'd21, 6'd22);
        chk("wrap_idx_a", rob_if.rob_dp_idx_o, {5'd31, 5'd30});
        tick();
        dispatch(2'b11, 6'd42, 6'd43, 6'd23, 6'd24);
        chk("wrap_idx_b", rob_if.rob_dp_idx_o, {5'd1, 5'd0});
        tick(); idle();
        complete(2'b11, 30, 31, 2'b00);
        tick(); idle();
        complete(2'b11, 0, 1, 2'b00);
        chk("wrap_told_a", rob_if.rt_phy_reg_o, {6'd22, 6'd21});
        tick(); idle();
        chk("wrap_told_b", rob_if.rt_phy_reg_o, {6'd24, 6'd23});
        tick();

        dispatch(2'b11, 6'd44, 6'd45, 6'd5, 6'd6);
        tick();
        dispatch(2'b11, 6'd46, 6'd47, 6'd7, 6'd8);
        tick();
        dispatch(2'b01, 6'd48, 6'd0, 6'd9, 6'd0);
        tick(); idle();
        chk("five_count", q.size(), 5);
        complete(2'b11, 2, 3, 2'b00);
        tick(); idle();
        chk("pre_rst_rt", rob_if.rt_num_o, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rt",    rob_if.rt_num_o, 0);
        chk("mid_rst_avail", rob_if.rob_dp_avail_o, 2'b11);
        chk("mid_rst_idx",   rob_if.rob_dp_idx_o, {5'd1, 5'd0});
        chk("mid_rst_phy",   rob_if.rt_phy_reg_o, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_rt",   rob_if.rt_num_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- Reorder buffer for the 2-wide OoO core.
- Allocates entries in program order at dispatch and marks them complete from the CDB.
- Retires up to two in-order completed entries per cycle.
- Drives the retire interface toward the freelist: old physical tag (Told) to free, new tag, valid mask. Signals mispredict rollback with the offending instruction's tag.

Parameters:
C_ROB_ENTRY_NUM, 32, number of ROB entries (power of 2)
C_DP_NUM, 2, dispatch lanes
C_RT_NUM, 2, retire lanes
C_CDB_NUM, 2, completion broadcasts per cycle
C_PR_ENTRY, 64, physical registers; tag width = clog2(C_PR_ENTRY)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
dp_num_i  in  C_DP_NUM  dispatch lane valid mask; lane 0 is oldest
dp_arch_rd_i  in  C_DP_NUM x 5  architectural destination per lane
dp_tag_i  in  C_DP_NUM x 6  new physical tag per lane
dp_tag_old_i  in  C_DP_NUM x 6  previous mapping (Told) per lane
rob_dp_avail_o  out  C_DP_NUM  free-entry mask: 2'b00 / 2'b01 / 2'b11
rob_dp_idx_o  out  C_DP_NUM x 5  ROB index assigned to each dispatch lane
cdb_valid_i  in  C_CDB_NUM  completion valid
cdb_rob_idx_i  in  C_CDB_NUM x 5  completing ROB index
cdb_mispred_i  in  C_CDB_NUM  completing branch mispredicted
rt_num_o  out  C_RT_NUM  retire lane valid mask (2'b00 / 2'b01 / 2'b11)
rt_phy_reg_o  out  C_RT_NUM x 6  Told to return to freelist
rt_tag_o  out  C_RT_NUM x 6  new tag being committed
rt_arch_rd_o  out  C_RT_NUM x 5  architectural destination committed
rollback_o  out  1  mispredict flush pulse
rollback_tag_o  out  6  tag of the mispredicted branch's destination

Behaviour:
- Reset (async, rst_n_i=0):
  - head=0, tail=0, count=0; all valid/complete/mispred bits cleared.
  - Outputs: rt_num_o=0, rollback_o=0, rob_dp_avail_o=2'b11, rob_dp_idx_o={1,0}; other data outputs 0.
  - Reset mid-operation discards all entries with no retire pulse.
- Availability:
  - From registered count only: free>=2 gives 2'b11, free==1 gives 2'b01, free==0 gives 2'b00.
  - Same-cycle retirement does not add capacity.
- Dispatch:
  - Legal dp_num_i values are 00, 01, 11.
  - Lane 0 is written at tail, lane 1 at tail+1 (mod C_ROB_ENTRY_NUM).
  - rob_dp_idx_o is combinational {tail+1, tail}.
  - Dispatching beyond rob_dp_avail_o is a protocol violation; flag it under assertion.
  - A written entry is valid, not complete.
- Completion:
  - For each cdb lane with valid set: set complete[idx], and set mispred[idx] from cdb_mispred_i.
  - Completion of an invalid entry is ignored.
  - Both lanes may target different entries in the same cycle.
- Retire (combinational from registered state):
  - Lane 0 retires if entry[head] is valid and complete.
  - Lane 1 retires if lane 0 retires, entry[head] is not mispredicted, and entry[head+1] is valid and complete.
  - Completion in cycle t allows retire no earlier than t+1.
- Rollback:
  - Lane 0 retires a mispredicted entry: rt_num_o=2'b01, rollback_o=1, rollback_tag_o=entry[head].tag, all in the same cycle.
  - Next state: all entries invalid, head=tail=head+1, count=0.
  - Dispatch and completion in the rollback cycle are ignored.
- Pointers and count:
  - head and tail wrap modulo C_ROB_ENTRY_NUM.
  - count_next = count + popcount(accepted dp) - popcount(rt); full at count==C_ROB_ENTRY_NUM.
  - Simultaneous dispatch and retire while full is legal only if dispatch respected avail (00).
- Zero-register destinations retire normally; the freelist filters Told==0.

Optional Feature:
- ROB_DEBUG_EN defined: adds outputs head_o, tail_o (5b), count_o (6b) and the per-entry valid/complete vectors.
- ROB_DEBUG_EN also enables SVA checks: dp overflow, illegal dp_num 10, count range.
- Undefined: those ports and assertions are absent; functionality is identical.

Decomposition:
- Shared package (sys_defs):
  - ROB_ENTRY struct {valid, complete, mispred, arch_rd, tag, tag_old}.
  - ROB_FL struct {rt_num, phy_reg, tag}, consumed directly by the freelist's rob_fl_i.
  - DP_ROB and ROB_DP structs.
  - Constants ROB_ENTRY_NUM, ROB_IDX_W, ZERO_PREG.
- One sub-module, rob_retire_sel: combinational retire-lane selection plus mispredict gating from head/head+1 entries.

Test Plan:
- Reset then dp_num=11 (tags 32/33, Told 1/2) -> rob_dp_idx_o={1,0}; next cycle count=2, rob_dp_avail_o=11.
- Complete idx1, then idx0 a cycle later -> rt_num_o=11 one cycle after idx0 completes, rt_phy_reg_o={2,1}, count=0.
- Fill to 31 entries -> avail=01; dispatch 01 -> avail=00; retire one -> avail=01 the following cycle.
- Head entry mispredicted and complete, head+1 complete -> rt_num_o=01, rollback_o=1, rollback_tag_o=head tag; next cycle count=0, head=tail=old head+1.
- Wrap: head=tail=30, dispatch 11 twice -> indices {31,30} then {1,0}; retire four in order -> correct Told sequence.
- Assert rst_n_i low mid-stream with 5 entries -> outputs zero immediately, avail=11, no retire pulses afterward.
